// File: rtl/radix_bist.sv
// Iterative radix-4 modified-Booth 8x8 unsigned multiplier with a built-in
// self-test mode that checks LFSR-generated patterns against a plain multiply.
module radix_bist #(
    parameter int N_PATTERNS = 32
) (
    input  logic        clk,
    input  logic        user_reset,
    input  logic        active_test,
    input  logic [7:0]  user_x,
    input  logic [7:0]  user_y,
    input  logic        user_start,
    output logic [15:0] result,
    output logic        ready
);

    localparam int PW = (N_PATTERNS > 1) ? $clog2(N_PATTERNS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        NEXT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_r;
    logic               mode_r;
    logic [7:0]         x_r;
    logic [7:0]         y_r;
    logic signed [17:0] acc_r;
    logic [2:0]         cnt_r;
    logic [PW-1:0]      pat_r;
    logic [15:0]        mism_r;
    logic [7:0]         lfsr_x_r;
    logic [7:0]         lfsr_y_r;

    logic [10:0]        y_ext_s;
    logic [2:0]         digit_s;
    logic [3:0]         shamt_s;
    logic signed [17:0] pp_s;
    logic signed [17:0] acc_next_s;
    logic [15:0]        ref_s;
    logic [15:0]        mism_next_s;

    // Booth digit {-2,-1,0,+1,+2} times X, sign-extended to accumulator width
    function automatic logic signed [17:0] booth_pp(input logic [2:0] bits, input logic [7:0] x);
        logic signed [17:0] x_ext;
        x_ext = {10'd0, x};
        case (bits)
            3'b001, 3'b010: booth_pp = x_ext;
            3'b011:         booth_pp = x_ext <<< 1;
            3'b100:         booth_pp = -(x_ext <<< 1);
            3'b101, 3'b110: booth_pp = -x_ext;
            default:        booth_pp = 18'sd0;
        endcase
    endfunction

    // Fibonacci LFSR step for x^8+x^6+x^5+x^4+1
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        lfsr_step = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Datapath: current Booth partial product, reference product, mismatch update
    always_comb begin
        y_ext_s    = {2'b00, y_r, 1'b0};
        shamt_s    = {cnt_r, 1'b0};
        digit_s    = y_ext_s[shamt_s +: 3];
        pp_s       = booth_pp(digit_s, x_r);
        acc_next_s = acc_r + (pp_s <<< shamt_s);
        ref_s      = 16'(x_r) * 16'(y_r);
        if ((acc_r[15:0] != ref_s) && (mism_r != 16'hFFFF)) begin
            mism_next_s = mism_r + 16'd1;
        end else begin
            mism_next_s = mism_r;
        end
    end

    // Control FSM with registered result/ready
    always_ff @(posedge clk) begin
        if (user_reset) begin
            state_r  <= IDLE;
            mode_r   <= 1'b0;
            x_r      <= 8'd0;
            y_r      <= 8'd0;
            acc_r    <= 18'sd0;
            cnt_r    <= 3'd0;
            pat_r    <= '0;
            mism_r   <= 16'd0;
            lfsr_x_r <= 8'h01;
            lfsr_y_r <= 8'hFF;
            result   <= 16'd0;
            ready    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (user_start) begin
                        mode_r  <= active_test;
                        acc_r   <= 18'sd0;
                        cnt_r   <= 3'd0;
                        pat_r   <= '0;
                        state_r <= CALC;
                        if (active_test) begin
                            // first pattern uses the seeds, LFSRs move on to pattern 2
                            x_r      <= 8'h01;
                            y_r      <= 8'hFF;
                            lfsr_x_r <= lfsr_step(8'h01);
                            lfsr_y_r <= lfsr_step(8'hFF);
                            mism_r   <= 16'd0;
                        end else begin
                            x_r <= user_x;
                            y_r <= user_y;
                        end
                    end
                end
                CALC: begin
                    acc_r <= acc_next_s;
                    if (cnt_r == 3'd4) begin
                        cnt_r <= 3'd0;
                        if (mode_r) begin
                            state_r <= NEXT;
                        end else begin
                            result  <= acc_next_s[15:0];
                            ready   <= 1'b1;
                            state_r <= DONE;
                        end
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                NEXT: begin
                    mism_r <= mism_next_s;
                    if (pat_r == PW'(N_PATTERNS - 1)) begin
                        result  <= mism_next_s;
                        ready   <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        pat_r    <= pat_r + 1'b1;
                        x_r      <= lfsr_x_r;
                        y_r      <= lfsr_y_r;
                        lfsr_x_r <= lfsr_step(lfsr_x_r);
                        lfsr_y_r <= lfsr_step(lfsr_y_r);
                        acc_r    <= 18'sd0;
                        cnt_r    <= 3'd0;
                        state_r  <= CALC;
                    end
                end
                DONE: begin
                    if (!user_start) begin
                        ready   <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    ready   <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_radix_bist.sv
// Self-checking bench for radix_bist: directed cases, reset abort, self-test
// run and a randomized user-mode regression against a behavioural x*y model.
module tb_radix_bist;

    logic        clk = 1'b0;
    logic        user_reset;
    logic        active_test;
    logic [7:0]  user_x;
    logic [7:0]  user_y;
    logic        user_start;
    logic [15:0] result;
    logic        ready;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    radix_bist #(.N_PATTERNS(32)) dut (
        .clk(clk),
        .user_reset(user_reset),
        .active_test(active_test),
        .user_x(user_x),
        .user_y(user_y),
        .user_start(user_start),
        .result(result),
        .ready(ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One user-mode multiply: start held for 'hold' edges, checked edge by edge
    task automatic run_user(input logic [7:0] x, input logic [7:0] y, input int hold,
                            input bit scramble, input string name);
        logic [15:0] exp_v;
        bit early;
        exp_v = 16'(x) * 16'(y);
        user_x = x;
        user_y = y;
        active_test = 1'b0;
        early = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            user_start = (e <= hold);
            tick();
            if (scramble) begin
                user_x = 8'($urandom);
                user_y = 8'($urandom);
                active_test = 1'($urandom_range(0, 1));
            end
            if (e < 6 && ready !== 1'b0) early = 1'b1;
        end
        n_vec++;
        if (early) begin
            n_err++;
            $display("FAIL %s early_ready: ready rose before edge 6", name);
        end
        n_vec++;
        if (ready !== 1'b1 || result !== exp_v) begin
            n_err++;
            $display("FAIL %s product: ready=%b result=%0d expected ready=1 result=%0d", name, ready, result, exp_v);
        end
        for (int e = 7; e <= hold; e++) begin
            tick();
            n_vec++;
            if (ready !== 1'b1 || result !== exp_v) begin
                n_err++;
                $display("FAIL %s hold: ready=%b result=%0d expected ready=1 result=%0d", name, ready, result, exp_v);
            end
        end
        user_start = 1'b0;
        active_test = 1'b0;
        tick();
        n_vec++;
        if (ready !== 1'b0 || result !== exp_v) begin
            n_err++;
            $display("FAIL %s release: ready=%b result=%0d expected ready=0 result=%0d", name, ready, result, exp_v);
        end
    endtask

    task automatic test_reset();
        user_reset = 1'b1;
        active_test = 1'b0;
        user_start = 1'b0;
        user_x = 8'd0;
        user_y = 8'd0;
        tick();
        tick();
        n_vec++;
        if (ready !== 1'b0 || result !== 16'h0000) begin
            n_err++;
            $display("FAIL reset: ready=%b result=%h expected ready=0 result=0000", ready, result);
        end
        user_reset = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        run_user(8'd18, 8'd100, 3, 1'b0, "x18_y100");
        run_user(8'd255, 8'd255, 1, 1'b0, "x255_y255");
        run_user(8'd0, 8'd200, 1, 1'b0, "x0_y200");
        run_user(8'd1, 8'd1, 1, 1'b0, "x1_y1");
        run_user(8'd170, 8'd85, 1, 1'b0, "x170_y85");
        run_user(8'd123, 8'd45, 10, 1'b0, "held_start");
    endtask

    task automatic test_scramble();
        for (int i = 0; i < 8; i++) begin
            run_user(8'($urandom), 8'($urandom), 2, 1'b1, "scramble");
        end
    endtask

    task automatic test_reset_mid();
        bit stray;
        user_x = 8'd50;
        user_y = 8'd60;
        active_test = 1'b0;
        user_start = 1'b1;
        tick();
        user_start = 1'b0;
        tick();
        tick();
        user_reset = 1'b1;
        tick();
        n_vec++;
        if (ready !== 1'b0 || result !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_mid: ready=%b result=%h expected ready=0 result=0000", ready, result);
        end
        user_reset = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ready !== 1'b0 || result !== 16'h0000) stray = 1'b1;
        end
        n_vec++;
        if (stray) begin
            n_err++;
            $display("FAIL reset_abort: aborted op produced ready=%b result=%h, expected none", ready, result);
        end
        run_user(8'd7, 8'd9, 1, 1'b0, "after_reset");
    endtask

    task automatic test_selftest();
        bit early;
        active_test = 1'b1;
        user_start = 1'b1;
        tick();
        user_start = 1'b0;
        early = 1'b0;
        for (int e = 2; e <= 192; e++) begin
            tick();
            if (ready !== 1'b0) early = 1'b1;
        end
        n_vec++;
        if (early) begin
            n_err++;
            $display("FAIL bist_early: ready rose before edge 193");
        end
        tick();
        n_vec++;
        if (ready !== 1'b1 || result !== 16'h0000) begin
            n_err++;
            $display("FAIL bist_done: ready=%b count=%h expected ready=1 count=0000", ready, result);
        end
        tick();
        n_vec++;
        if (ready !== 1'b0) begin
            n_err++;
            $display("FAIL bist_release: ready=%b expected 0", ready);
        end
        active_test = 1'b0;
        run_user(8'd12, 8'd11, 1, 1'b0, "after_bist");
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++) begin
            run_user(8'($urandom), 8'($urandom), int'($urandom_range(1, 7)),
                     1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_scramble();
        test_reset_mid();
        test_selftest();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
